// File: rtl/mem_logic.sv
// AGC-style address translator: flattens CPU address plus EB/FB/SB bank registers into a
// 16-bit physical word address, with a registered last-access capture and fixed-write fault flag.
// Optional feature: define MEM_LOGIC_SUPERBANK_EN to enable the superbank remap of banks 24-31.
module mem_logic (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  eBank,
  input  logic [4:0]  fBank,
  input  logic        superBank,
  input  logic [11:0] memAddress,
  input  logic [2:0]  opcode,
  output logic [15:0] finalAddress,
  output logic [1:0]  region,
  output logic [15:0] lastAddress,
  output logic        fixedWriteFault
);

  localparam logic [1:0] REG_ERASABLE  = 2'd0;
  localparam logic [1:0] REG_SWITCH_E  = 2'd1;
  localparam logic [1:0] REG_SWITCH_F  = 2'd2;
  localparam logic [1:0] REG_FIXED     = 2'd3;

  logic [5:0] bank6;
  logic       access;
  logic       write;

  always_comb begin
    region = REG_FIXED;
    case (memAddress[11:8])
      4'h0, 4'h1, 4'h2:       region = REG_ERASABLE;
      4'h3:                   region = REG_SWITCH_E;
      4'h4, 4'h5, 4'h6, 4'h7: region = REG_SWITCH_F;
      default:                region = REG_FIXED;
    endcase
  end

`ifdef MEM_LOGIC_SUPERBANK_EN
  // Superbank only lifts the top eight fixed banks (24-31) to 32-39.
  always_comb begin
    bank6 = {1'b0, fBank};
    if (superBank && (fBank[4:3] == 2'b11))
      bank6 = {3'b100, fBank[2:0]};
  end
`else
  logic unused_superbank;
  assign unused_superbank = superBank;

  always_comb begin
    bank6 = {1'b0, fBank};
  end
`endif

  always_comb begin
    finalAddress = {4'b0, memAddress};
    case (region)
      REG_ERASABLE: finalAddress = {4'b0, memAddress};
      REG_SWITCH_E: finalAddress = {5'b0, eBank, memAddress[7:0]};
      REG_SWITCH_F: finalAddress = {bank6, memAddress[9:0]};
      default:      finalAddress = {4'b0, memAddress};
    endcase
  end

  assign access = (opcode[2:1] == 2'b00);
  assign write  = (opcode == 3'b001);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastAddress     <= 16'h0000;
      fixedWriteFault <= 1'b0;
    end else begin
      if (access)
        lastAddress <= finalAddress;
      if (write && region[1])
        fixedWriteFault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_logic.sv
// Self-checking bench for mem_logic: arithmetic reference model plus literal test-plan vectors.
module tb_mem_logic;

  logic        clk;
  logic        rst_n;
  logic [2:0]  eBank;
  logic [4:0]  fBank;
  logic        superBank;
  logic [11:0] memAddress;
  logic [2:0]  opcode;
  logic [15:0] finalAddress;
  logic [1:0]  region;
  logic [15:0] lastAddress;
  logic        fixedWriteFault;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_last;
  logic        exp_fault;
  event        chk_ev;

  mem_logic dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .eBank           (eBank),
    .fBank           (fBank),
    .superBank       (superBank),
    .memAddress      (memAddress),
    .opcode          (opcode),
    .finalAddress    (finalAddress),
    .region          (region),
    .lastAddress     (lastAddress),
    .fixedWriteFault (fixedWriteFault)
  );

  function automatic int ref_region(int a);
    if (a < 'h300) return 0;
    else if (a < 'h400) return 1;
    else if (a < 'h800) return 2;
    else return 3;
  endfunction

  function automatic int ref_addr(int ea, int fb, int sb, int a);
    int b;
    case (ref_region(a))
      1: return ea * 256 + (a % 256);
      2: begin
        b = fb;
`ifdef MEM_LOGIC_SUPERBANK_EN
        if (sb != 0 && fb >= 24) b = fb + 8;
`else
        if (sb < 0) b = 0;
`endif
        return b * 1024 + (a % 1024);
      end
      default: return a;
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Single compare process: checks every output against the model whenever sampled.
  always @(chk_ev) begin
    check("finalAddress", int'(finalAddress),
          ref_addr(int'(eBank), int'(fBank), int'(superBank), int'(memAddress)));
    check("region", int'(region), ref_region(int'(memAddress)));
    check("lastAddress", int'(lastAddress), int'(exp_last));
    check("fixedWriteFault", int'(fixedWriteFault), int'(exp_fault));
  end

  task automatic sample();
    #1;
    -> chk_ev;
    #1;
  endtask

  task automatic apply(input int ea, input int fb, input int sb, input int a, input int op);
    eBank      = 3'(ea);
    fBank      = 5'(fb);
    superBank  = 1'(sb);
    memAddress = 12'(a);
    opcode     = 3'(op);
    sample();
  endtask

  task automatic tick();
    logic [15:0] nl;
    logic        nf;
    nl = exp_last;
    nf = exp_fault;
    if (opcode == 3'b000 || opcode == 3'b001)
      nl = 16'(ref_addr(int'(eBank), int'(fBank), int'(superBank), int'(memAddress)));
    if (opcode == 3'b001 && memAddress >= 12'h400)
      nf = 1'b1;
    #4 clk = 1'b1;
    if (rst_n) begin
      exp_last  = nl;
      exp_fault = nf;
    end
    #5 clk = 1'b0;
    sample();
  endtask

  task automatic lit(string name, input int ea, input int fb, input int sb, input int a,
                     input int exp_addr, input int exp_reg);
    apply(ea, fb, sb, a, 0);
    check({name, "_addr"}, int'(finalAddress), exp_addr);
    check({name, "_reg"}, int'(region), exp_reg);
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    eBank = '0; fBank = '0; superBank = 1'b0; memAddress = '0; opcode = 3'b000;
    exp_last = 16'h0; exp_fault = 1'b0;
    #2;
    check("reset_last", int'(lastAddress), 0);
    check("reset_fault", int'(fixedWriteFault), 0);
    sample();
    rst_n = 1'b1;
    #2;

    lit("r0_a", 0, 0, 0, 'h2CC, 'h02CC, 0);
    lit("r0_b", 0, 0, 0, 'h10F, 'h010F, 0);
    lit("r1_a", 0, 0, 0, 'h3F0, 'h00F0, 1);
    lit("r1_b", 5, 0, 0, 'h333, 'h0533, 1);
    lit("r3_a", 0, 0, 0, 'hF8E, 'h0F8E, 3);
    lit("r3_b", 0, 0, 0, 'h871, 'h0871, 3);
    lit("r2_a", 0, 'h15, 0, 'h7E0, 'h57E0, 2);
    lit("r2_b", 0, 'h09, 0, 'h41F, 'h241F, 2);
    lit("r2_c", 0, 'h04, 0, 'h6AA, 'h12AA, 2);
    lit("r2_d", 0, 'h1C, 0, 'h7FF, 'h73FF, 2);
`ifdef MEM_LOGIC_SUPERBANK_EN
    lit("sb_hi", 0, 'h19, 1, 'h400, 'h8400, 2);
`else
    lit("sb_hi", 0, 'h19, 1, 'h400, 'h6400, 2);
`endif
    lit("sb_lo", 0, 'h09, 1, 'h41F, 'h241F, 2);
    lit("sb_r0", 7, 'h1F, 1, 'h2FF, 'h02FF, 0);
    lit("eb_r2", 7, 'h00, 0, 'h5FF, 'h01FF, 2);

    rst_n = 1'b0; sample(); rst_n = 1'b1; sample();
    apply(5, 0, 0, 'h300, 1); tick();
    check("wr_r1_last", int'(lastAddress), 'h0500);
    check("wr_r1_fault", int'(fixedWriteFault), 0);
    apply(5, 0, 0, 'h900, 1); tick();
    check("wr_r3_last", int'(lastAddress), 'h0900);
    check("wr_r3_fault", int'(fixedWriteFault), 1);
    apply(2, 3, 0, 'h123, 2); tick();
    check("noacc_last", int'(lastAddress), 'h0900);
    apply(0, 0, 0, 'h10F, 0); tick();
    check("rd_last", int'(lastAddress), 'h010F);
    check("sticky_fault", int'(fixedWriteFault), 1);

    rst_n = 1'b0;
    exp_last = 16'h0; exp_fault = 1'b0;
    #1;
    check("async_last", int'(lastAddress), 0);
    check("async_fault", int'(fixedWriteFault), 0);
    apply(0, 0, 0, 'h900, 1); tick();
    check("rst_edge_last", int'(lastAddress), 0);
    check("rst_edge_fault", int'(fixedWriteFault), 0);
    rst_n = 1'b1;
    sample();

    apply(1, 0, 0, 'h3FF, 1); tick();
    check("bnd_3ff_fault", int'(fixedWriteFault), 0);
    apply(0, 'h1F, 1, 'h400, 1); tick();
    check("bnd_400_fault", int'(fixedWriteFault), 1);
    rst_n = 1'b0; exp_last = 16'h0; exp_fault = 1'b0; sample(); rst_n = 1'b1; sample();

    for (int i = 0; i < 60; i++) begin
      apply(int'($urandom_range(7)), int'($urandom_range(31)), int'($urandom_range(1)),
            int'($urandom_range(4095)), int'($urandom_range(7)));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
